// File: rtl/load_store_station.sv
// Load/store reservation station: a 4-entry in-order circular buffer.
// Memory ops are dispatched at the tail and issue strictly from the head.
// Source operands wake up on CDB broadcasts. Recovery squashes entries
// from the tail one at a time, youngest first.
module load_store_station (
    input  logic        clk,
    input  logic        rst,
    // dispatch side
    input  logic        dispatch,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [15:0] immed,
    input  logic [3:0]  rob_in,
    input  logic [5:0]  p_rd_in,
    input  logic [5:0]  p_rs_in,
    input  logic [5:0]  p_rt_in,
    input  logic        rs_rdy_in,
    input  logic        rt_rdy_in,
    // wakeup
    input  logic        cdb_valid,
    input  logic [5:0]  cdb_p_rd,
    // backpressure
    input  logic        sq_full,
    input  logic        stall_hazard,
    // recovery
    input  logic        recover,
    input  logic [3:0]  rec_rob,
    // issue side
    output logic        lss_full,
    output logic        issue,
    output logic        mem_ren_out,
    output logic        mem_wen_out,
    output logic [15:0] immed_out,
    output logic [3:0]  rob_out,
    output logic [5:0]  p_rd_out,
    output logic [5:0]  p_rs_out,
    output logic [5:0]  p_rt_out
);

    localparam int DEPTH = 4;

    // Data carried by an entry that only matters while the entry is valid.
    typedef struct packed {
        logic        mem_ren;
        logic        mem_wen;
        logic [15:0] immed;
        logic [3:0]  rob;
        logic [5:0]  p_rd;
        logic [5:0]  p_rs;
        logic [5:0]  p_rt;
    } payload_t;

    logic [1:0]       head_q, head_d;
    logic [1:0]       tail_q, tail_d;
    logic [2:0]       count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] rs_rdy_q, rs_rdy_d;
    logic [DEPTH-1:0] rt_rdy_q, rt_rdy_d;
    payload_t         payload_q [DEPTH];
    payload_t         payload_d [DEPTH];

    logic [1:0] tail_m1;
    payload_t   head_p;
    logic       head_valid;
    logic       head_is_store;
    logic       operands_ready;
    logic       disp_acc;
    logic       rec_acc;
    logic       pop_squashed;
    logic       pop;

    // Head decode, issue decision and the accept/squash/pop qualifiers.
    always_comb begin
        tail_m1        = tail_q - 2'd1;
        head_p         = payload_q[head_q];
        head_valid     = valid_q[head_q];
        head_is_store  = head_p.mem_wen;
        // Loads need only the base register; stores also need the data.
        operands_ready = rs_rdy_q[head_q] && (!head_is_store || rt_rdy_q[head_q]);

        issue = head_valid && operands_ready && !stall_hazard && !recover
                && !(head_is_store && sq_full);

        lss_full = (count_q == 3'd4);
        disp_acc = dispatch && !lss_full && !recover;
        rec_acc  = recover && (count_q != 3'd0) && (payload_q[tail_m1].rob == rec_rob);

        // A squashed entry left at the head is retired silently. Held off
        // during recovery so the count never moves twice in one cycle.
        pop_squashed = (count_q != 3'd0) && !head_valid && !recover;
        pop          = issue || pop_squashed;
    end

    // Gate memory strobes so nothing downstream sees a request without issue.
    always_comb begin
        mem_ren_out = issue && head_p.mem_ren;
        mem_wen_out = issue && head_p.mem_wen;
        immed_out   = head_p.immed;
        rob_out     = head_p.rob;
        p_rd_out    = head_p.p_rd;
        p_rs_out    = head_p.p_rs;
        p_rt_out    = head_p.p_rt;
    end

    // Next-state: wakeup, pop at head, write at tail, squash at tail.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        head_d    = head_q;
        tail_d    = tail_q;
        valid_d   = valid_q;
        rs_rdy_d  = rs_rdy_q;
        rt_rdy_d  = rt_rdy_q;
        payload_d = payload_q;

        if (cdb_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && payload_q[i].p_rs == cdb_p_rd) rs_rdy_d[i] = 1'b1;
                if (valid_q[i] && payload_q[i].p_rt == cdb_p_rd) rt_rdy_d[i] = 1'b1;
            end
        end

        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 2'd1;
        end

        // The tail slot is never the head being popped: dispatch needs a free
        // slot, and issue needs a valid head, so count is strictly between.
        if (disp_acc) begin
            valid_d[tail_q]           = 1'b1;
            rs_rdy_d[tail_q]          = rs_rdy_in || (cdb_valid && cdb_p_rd == p_rs_in);
            rt_rdy_d[tail_q]          = rt_rdy_in || (cdb_valid && cdb_p_rd == p_rt_in);
            payload_d[tail_q].mem_ren = mem_ren;
            payload_d[tail_q].mem_wen = mem_wen;
            payload_d[tail_q].immed   = immed;
            payload_d[tail_q].rob     = rob_in;
            payload_d[tail_q].p_rd    = p_rd_in;
            payload_d[tail_q].p_rs    = p_rs_in;
            payload_d[tail_q].p_rt    = p_rt_in;
            tail_d                    = tail_q + 2'd1;
        end

        // Dispatch and issue are both blocked by recover, so this is exclusive.
        if (rec_acc) begin
            valid_d[tail_m1] = 1'b0;
            tail_d           = tail_m1;
        end

        count_d = count_q + {2'b00, disp_acc} - {2'b00, pop} - {2'b00, rec_acc};
    end

    // Control state: pointers, occupancy and per-entry valid/ready bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            rs_rdy_q <= '0;
            rt_rdy_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            rs_rdy_q <= rs_rdy_d;
            rt_rdy_q <= rt_rdy_d;
        end
    end

    // Entry payload storage.
    // NOTE: payload is left unreset; it is only observed behind a valid bit.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            payload_q[i] <= payload_d[i];
        end
    end

endmodule

// File: tb/tb_load_store_station.sv
// Directed bench for load_store_station. Stimulus pushes the expected issue
// record into a scoreboard queue; a monitor pops and compares on every issue.
module tb_load_store_station;

    logic        clk;
    logic        rst;
    logic        dispatch;
    logic        mem_ren;
    logic        mem_wen;
    logic [15:0] immed;
    logic [3:0]  rob_in;
    logic [5:0]  p_rd_in;
    logic [5:0]  p_rs_in;
    logic [5:0]  p_rt_in;
    logic        rs_rdy_in;
    logic        rt_rdy_in;
    logic        cdb_valid;
    logic [5:0]  cdb_p_rd;
    logic        sq_full;
    logic        stall_hazard;
    logic        recover;
    logic [3:0]  rec_rob;
    logic        lss_full;
    logic        issue;
    logic        mem_ren_out;
    logic        mem_wen_out;
    logic [15:0] immed_out;
    logic [3:0]  rob_out;
    logic [5:0]  p_rd_out;
    logic [5:0]  p_rs_out;
    logic [5:0]  p_rt_out;

    int          n_checks;
    int          n_fail;
    logic [39:0] sb [$];

    load_store_station dut (
        .clk          (clk),
        .rst          (rst),
        .dispatch     (dispatch),
        .mem_ren      (mem_ren),
        .mem_wen      (mem_wen),
        .immed        (immed),
        .rob_in       (rob_in),
        .p_rd_in      (p_rd_in),
        .p_rs_in      (p_rs_in),
        .p_rt_in      (p_rt_in),
        .rs_rdy_in    (rs_rdy_in),
        .rt_rdy_in    (rt_rdy_in),
        .cdb_valid    (cdb_valid),
        .cdb_p_rd     (cdb_p_rd),
        .sq_full      (sq_full),
        .stall_hazard (stall_hazard),
        .recover      (recover),
        .rec_rob      (rec_rob),
        .lss_full     (lss_full),
        .issue        (issue),
        .mem_ren_out  (mem_ren_out),
        .mem_wen_out  (mem_wen_out),
        .immed_out    (immed_out),
        .rob_out      (rob_out),
        .p_rd_out     (p_rd_out),
        .p_rs_out     (p_rs_out),
        .p_rt_out     (p_rt_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected issue record: {ren, wen, rob, p_rd, p_rs, p_rt, immed}.
    function automatic logic [39:0] exp_load(input logic [3:0] rob, input logic [5:0] prd,
                                             input logic [5:0] prs, input logic [15:0] imm);
        return {1'b1, 1'b0, rob, prd, prs, 6'd0, imm};
    endfunction

    function automatic logic [39:0] exp_store(input logic [3:0] rob, input logic [5:0] prs,
                                              input logic [5:0] prt, input logic [15:0] imm);
        return {1'b0, 1'b1, rob, 6'd0, prs, prt, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        dispatch  = 1'b0;
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        cdb_valid = 1'b0;
        recover   = 1'b0;
    endtask

    task automatic disp_load(input logic [3:0] rob, input logic [5:0] prd, input logic [5:0] prs,
                             input logic rsr, input logic [15:0] imm);
        dispatch  = 1'b1;
        mem_ren   = 1'b1;
        mem_wen   = 1'b0;
        rob_in    = rob;
        p_rd_in   = prd;
        p_rs_in   = prs;
        p_rt_in   = 6'd0;
        rs_rdy_in = rsr;
        rt_rdy_in = 1'b0;
        immed     = imm;
    endtask

    task automatic disp_store(input logic [3:0] rob, input logic [5:0] prs, input logic [5:0] prt,
                              input logic rsr, input logic rtr, input logic [15:0] imm);
        dispatch  = 1'b1;
        mem_ren   = 1'b0;
        mem_wen   = 1'b1;
        rob_in    = rob;
        p_rd_in   = 6'd0;
        p_rs_in   = prs;
        p_rt_in   = prt;
        rs_rdy_in = rsr;
        rt_rdy_in = rtr;
        immed     = imm;
    endtask

    // Monitor: compares every issued record against the scoreboard head.
    initial begin
        logic [39:0] exp_v;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                if (issue === 1'b1) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL sb_underflow: unexpected issue rob_out=%0h expected no issue", rob_out);
                    end else begin
                        exp_v = sb.pop_front();
                        check("issue_record",
                              {mem_ren_out, mem_wen_out, rob_out, p_rd_out, p_rs_out, p_rt_out, immed_out},
                              exp_v);
                    end
                end else begin
                    check("idle_strobes", {mem_ren_out, mem_wen_out}, 2'b00);
                end
            end
        end
    end

    // Global time bound.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] imm;
        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b0;
        immed        = '0;
        rob_in       = '0;
        p_rd_in      = '0;
        p_rs_in      = '0;
        p_rt_in      = '0;
        rs_rdy_in    = 1'b0;
        rt_rdy_in    = 1'b0;
        cdb_p_rd     = '0;
        sq_full      = 1'b0;
        stall_hazard = 1'b0;
        rec_rob      = '0;
        clr();

        // Reset state
        repeat (2) tick();
        check("rst_lss_full", lss_full, 0);
        check("rst_issue", issue, 0);
        check("rst_strobes", {mem_ren_out, mem_wen_out}, 2'b00);
        rst = 1'b1;
        tick();

        // Fill with stores while the store queue is full
        sq_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            imm = 16'h0100 + 16'(i);
            disp_store(4'(2 + i), 6'(1 + i), 6'(5 + i), 1'b1, 1'b1, imm);
            sb.push_back(exp_store(4'(2 + i), 6'(1 + i), 6'(5 + i), imm));
            #1;
            check("fill_no_issue", issue, 0);
            check("fill_not_full", lss_full, 0);
            tick();
        end
        disp_store(4'd6, 6'h09, 6'h0B, 1'b1, 1'b1, 16'h0106);
        #1;
        check("fill_full", lss_full, 1);
        check("fill_sq_blocks", issue, 0);
        tick();
        // Drain: first cycle still full, so the 5th dispatch stays dropped
        sq_full = 1'b0;
        #1;
        check("drain_still_full", lss_full, 1);
        check("drain_issue0", issue, 1);
        check("drain_store_strobe", mem_wen_out, 1);
        tick();
        clr();
        for (int k = 0; k < 3; k++) begin
            #1;
            check("drain_issue", issue, 1);
            check("drain_not_full", lss_full, 0);
            tick();
        end
        #1;
        check("drain_empty_issue", issue, 0);
        check("drain_empty_full", lss_full, 0);

        // Wakeup of a load after dispatch, no same-cycle bypass
        disp_load(4'd7, 6'h11, 6'h0A, 1'b0, 16'h0040);
        sb.push_back(exp_load(4'd7, 6'h11, 6'h0A, 16'h0040));
        tick();
        clr();
        #1;
        check("wake_wait", issue, 0);
        tick();
        cdb_valid = 1'b1;
        cdb_p_rd  = 6'h0A;
        #1;
        check("wake_no_bypass", issue, 0);
        tick();
        clr();
        #1;
        check("wake_issue", issue, 1);
        check("wake_ren", mem_ren_out, 1);
        tick();

        // Wakeup during the dispatch cycle
        disp_load(4'd8, 6'h12, 6'h15, 1'b0, 16'h0008);
        cdb_valid = 1'b1;
        cdb_p_rd  = 6'h15;
        sb.push_back(exp_load(4'd8, 6'h12, 6'h15, 16'h0008));
        tick();
        clr();
        #1;
        check("disp_wake_issue", issue, 1);
        tick();

        // Store waits for its data operand
        disp_store(4'd15, 6'h01, 6'h20, 1'b1, 1'b0, 16'h0F0F);
        sb.push_back(exp_store(4'd15, 6'h01, 6'h20, 16'h0F0F));
        tick();
        clr();
        #1;
        check("store_rt_wait", issue, 0);
        cdb_valid = 1'b1;
        cdb_p_rd  = 6'h20;
        tick();
        clr();
        #1;
        check("store_rt_issue", issue, 1);
        check("store_rt_wen", mem_wen_out, 1);
        tick();

        // Load passes a full store queue, store behind it stalls
        sq_full = 1'b1;
        disp_load(4'd9, 6'h13, 6'h02, 1'b1, 16'h0010);
        sb.push_back(exp_load(4'd9, 6'h13, 6'h02, 16'h0010));
        tick();
        disp_store(4'd10, 6'h04, 6'h05, 1'b1, 1'b1, 16'h0020);
        sb.push_back(exp_store(4'd10, 6'h04, 6'h05, 16'h0020));
        #1;
        check("load_past_sq", issue, 1);
        check("load_past_sq_ren", mem_ren_out, 1);
        tick();
        clr();
        for (int k = 0; k < 2; k++) begin
            #1;
            check("store_sq_stall", issue, 0);
            tick();
        end
        sq_full = 1'b0;
        #1;
        check("store_sq_release", issue, 1);
        tick();
        #1;
        check("store_sq_empty", issue, 0);

        // Recovery squashes rob 5 then 4; rob 9 does not match
        stall_hazard = 1'b1;
        disp_load(4'd3, 6'h03, 6'h01, 1'b1, 16'h0003);
        sb.push_back(exp_load(4'd3, 6'h03, 6'h01, 16'h0003));
        tick();
        disp_load(4'd4, 6'h04, 6'h01, 1'b1, 16'h0004);
        tick();
        disp_load(4'd5, 6'h05, 6'h01, 1'b1, 16'h0005);
        tick();
        clr();
        #1;
        check("stall_blocks", issue, 0);
        recover = 1'b1;
        rec_rob = 4'd5;
        tick();
        rec_rob = 4'd4;
        tick();
        rec_rob = 4'd9;
        tick();
        clr();
        disp_load(4'd11, 6'h21, 6'h01, 1'b1, 16'h0011);
        sb.push_back(exp_load(4'd11, 6'h21, 6'h01, 16'h0011));
        tick();
        disp_load(4'd12, 6'h22, 6'h01, 1'b1, 16'h0012);
        sb.push_back(exp_load(4'd12, 6'h22, 6'h01, 16'h0012));
        tick();
        #1;
        check("rec_count3", lss_full, 0);
        disp_load(4'd13, 6'h23, 6'h01, 1'b1, 16'h0013);
        sb.push_back(exp_load(4'd13, 6'h23, 6'h01, 16'h0013));
        tick();
        clr();
        #1;
        check("rec_refill_full", lss_full, 1);
        stall_hazard = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rec_drain_issue", issue, 1);
            tick();
        end
        #1;
        check("rec_drain_empty", issue, 0);

        // Reset mid-fill
        stall_hazard = 1'b1;
        disp_load(4'd1, 6'h31, 6'h01, 1'b1, 16'h0001);
        tick();
        disp_load(4'd2, 6'h32, 6'h01, 1'b1, 16'h0002);
        tick();
        clr();
        stall_hazard = 1'b0;
        rst = 1'b0;
        #1;
        check("midrst_full", lss_full, 0);
        check("midrst_issue", issue, 0);
        check("midrst_strobes", {mem_ren_out, mem_wen_out}, 2'b00);
        tick();
        tick();
        rst = 1'b1;
        disp_load(4'd14, 6'h0E, 6'h07, 1'b1, 16'h0E0E);
        sb.push_back(exp_load(4'd14, 6'h0E, 6'h07, 16'h0E0E));
        tick();
        clr();
        #1;
        check("post_rst_issue", issue, 1);
        tick();
        stall_hazard = 1'b1;
        for (int i = 0; i < 4; i++) begin
            imm = 16'h0A00 + 16'(i);
            disp_load(4'(i), 6'(16 + i), 6'h02, 1'b1, imm);
            sb.push_back(exp_load(4'(i), 6'(16 + i), 6'h02, imm));
            tick();
        end
        clr();
        #1;
        check("post_rst_full", lss_full, 1);
        stall_hazard = 1'b0;
        repeat (4) tick();
        #1;
        check("post_rst_empty_full", lss_full, 0);
        check("post_rst_empty_issue", issue, 0);

        repeat (3) tick();
        check("sb_empty", 64'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
